// File: rtl/rv32_alu_if.sv
// Operand/result bundle between the execute-stage datapath and the ALU.
//   i_alu_op : 6-bit operation select
//   i_a/i_b  : operands (i_b low bits also carry the shift amount)
//   o_c      : combinational result
//   o_zero   : combinational, high when o_c is zero
//   o_c_q    : o_c registered on the rising clock edge
interface rv32_alu_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [5:0]            i_alu_op;
  logic [DATA_WIDTH-1:0] i_a;
  logic [DATA_WIDTH-1:0] i_b;
  logic [DATA_WIDTH-1:0] o_c;
  logic                  o_zero;
  logic [DATA_WIDTH-1:0] o_c_q;

  // Datapath side: drives operands, consumes results
  modport master (
    output i_alu_op, i_a, i_b,
    input  o_c, o_zero, o_c_q
  );

  // ALU side
  modport slave (
    input  i_alu_op, i_a, i_b,
    output o_c, o_zero, o_c_q
  );
endinterface

// File: rtl/rv32_alu.sv
// RV32 integer ALU for the execute stage.
//   i_clk   : clock, used only by the registered result
//   i_rst_n : asynchronous active-low reset, clears o_c_q
//   alu     : operand/result bundle (slave side)
// o_c and o_zero are purely combinational from the operands and opcode;
// o_c_q is a registered copy for writeback/branch logic.
module rv32_alu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  rv32_alu_if.slave  alu
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_INV  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_SLL  = 6'd7;
  localparam logic [5:0] OP_SRL  = 6'd8;
  localparam logic [5:0] OP_SRA  = 6'd9;
  localparam logic [5:0] OP_SLTU = 6'd10;

  logic [DATA_WIDTH-1:0] result_c;
  logic [SHAMT_W-1:0]    shamt_c;
  logic                  lt_signed_c;
  logic                  lt_unsigned_c;

  // Only the low bits of operand B select the shift distance
  assign shamt_c = alu.i_b[SHAMT_W-1:0];

  // True signed compare, so overflowing differences still order correctly
  assign lt_signed_c   = $signed(alu.i_a) < $signed(alu.i_b);
  assign lt_unsigned_c = alu.i_a < alu.i_b;

  // Result mux; unknown opcodes yield zero
  always_comb begin
    result_c = '0;
    case (alu.i_alu_op)
      OP_ADD:  result_c = alu.i_a + alu.i_b;
      OP_SUB:  result_c = alu.i_a - alu.i_b;
      OP_AND:  result_c = alu.i_a & alu.i_b;
      OP_OR:   result_c = alu.i_a | alu.i_b;
      OP_XOR:  result_c = alu.i_a ^ alu.i_b;
      OP_INV:  result_c = ~alu.i_a;
      OP_SLT:  result_c = DATA_WIDTH'(lt_signed_c);
      OP_SLL:  result_c = alu.i_a << shamt_c;
      OP_SRL:  result_c = alu.i_a >> shamt_c;
      OP_SRA:  result_c = DATA_WIDTH'($signed(alu.i_a) >>> shamt_c);
      OP_SLTU: result_c = DATA_WIDTH'(lt_unsigned_c);
      default: result_c = '0;
    endcase
  end

  assign alu.o_c    = result_c;
  assign alu.o_zero = (result_c == '0);

  // Registered copy of the result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu.o_c_q <= '0;
    end else begin
      alu.o_c_q <= result_c;
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: directed cases, reset behaviour of the
// registered result, then randomized operations against an arithmetic model.
module tb_rv32_alu;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rv32_alu_if #(.DATA_WIDTH(W)) bus ();

  rv32_alu #(.DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .alu     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain integer arithmetic on 64-bit values
  function automatic logic [31:0] model(input int op, input logic [31:0] a32, input logic [31:0] b32);
    longint unsigned m;
    longint unsigned a;
    longint unsigned b;
    longint unsigned p;
    longint          sa;
    longint          sb;
    longint          r;
    int              sh;
    m  = 64'h1_0000_0000;
    a  = longint'(a32);
    b  = longint'(b32);
    sh = int'(b % 32);
    p  = longint'(1) << sh;
    sa = (a >= 64'h8000_0000) ? longint'(a) - longint'(m) : longint'(a);
    sb = (b >= 64'h8000_0000) ? longint'(b) - longint'(m) : longint'(b);
    case (op)
      0:  r = longint'((a + b) % m);
      1:  r = longint'((a + m - b) % m);
      2:  r = longint'(a & b);
      3:  r = longint'(a | b);
      4:  r = longint'(a ^ b);
      5:  r = longint'(m - 1 - a);
      6:  r = (sa < sb) ? 1 : 0;
      7:  r = longint'((a * p) % m);
      8:  r = longint'(a / p);
      9:  begin
            if (sa >= 0) r = sa / longint'(p);
            else         r = -((-sa + longint'(p) - 1) / longint'(p));
            if (r < 0) r = r + longint'(m);
          end
      10: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one operation between edges, check combinational outputs, then the capture
  task automatic step(input string tag, input int op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    bus.i_alu_op = 6'(op);
    bus.i_a      = a;
    bus.i_b      = b;
    #1;
    check({tag, ".c"}, bus.o_c, exp);
    check({tag, ".zero"}, 32'(bus.o_zero), 32'(exp == 32'h0));
    @(posedge clk);
    #1;
    check({tag, ".c_q"}, bus.o_c_q, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          rop;
    errors = 0;
    checks = 0;
    rst_n        = 1'b0;
    bus.i_alu_op = 6'd0;
    bus.i_a      = 32'h0;
    bus.i_b      = 32'h0;

    // Reset state of the register
    @(posedge clk);
    #1;
    check("reset.c_q", bus.o_c_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, expectations written literally
    step("add_1_1",    0,  32'h1,        32'h1,        32'h2);
    step("sub_1_1",    1,  32'h1,        32'h1,        32'h0);
    step("add_wrap",   0,  32'hffffffff, 32'h1,        32'h0);
    step("and",        2,  32'h1001,     32'h100001,   32'h1);
    step("or",         3,  32'h101,      32'h10001,    32'h10101);
    step("xor",        4,  32'h101,      32'h10001,    32'h10100);
    step("inv",        5,  32'h1,        32'h12345678, 32'hfffffffe);
    step("slt_pos",    6,  32'h101,      32'h10001,    32'h1);
    step("slt_neg",    6,  32'hffffffff, 32'h1,        32'h1);
    step("slt_ovf",    6,  32'h80000000, 32'h7fffffff, 32'h1);
    step("slt_ovf_r",  6,  32'h7fffffff, 32'h80000000, 32'h0);
    step("sltu",       10, 32'hffffffff, 32'h1,        32'h0);
    step("sll_16",     7,  32'h1,        32'h10,       32'h10000);
    step("srl_1",      8,  32'h100,      32'h1,        32'h80);
    step("sra_3",      9,  32'hfffffff0, 32'h3,        32'hfffffffe);
    step("sra_31",     9,  32'h80000000, 32'h1f,       32'hffffffff);
    step("sll_hi_b",   7,  32'h1,        32'h21,       32'h2);
    step("sll_0",      7,  32'hdeadbeef, 32'h0,        32'hdeadbeef);
    step("sra_0",      9,  32'h80000001, 32'h20,       32'h80000001);
    step("undef_3f",   63, 32'hffffffff, 32'hffffffff, 32'h0);
    step("undef_0b",   11, 32'h12345678, 32'h1,        32'h0);

    // Registered path around a mid-operation reset
    @(negedge clk);
    bus.i_alu_op = 6'd0;
    bus.i_a      = 32'h2;
    bus.i_b      = 32'h3;
    @(posedge clk);
    #1;
    check("rst_seq.capture", bus.o_c_q, 32'h5);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_seq.cleared", bus.o_c_q, 32'h0);
    check("rst_seq.c_live", bus.o_c, 32'h5);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_seq.held", bus.o_c_q, 32'h0);
    @(posedge clk);
    #1;
    check("rst_seq.recapture", bus.o_c_q, 32'h5);

    // Randomized operations, mostly defined opcodes, occasionally any opcode
    for (int i = 0; i < 300; i++) begin
      rop = (i % 8 == 7) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 10));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = ra;
        2: rb = 32'h0000001f;
        3: ra = 32'hffffffff;
        default: ;
      endcase
      step($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
